wb_arbiter: RTL
===============

# wb_arbiter

Sequences the single register-file write port at the end of the pipeline. It arbitrates between the in-order writeback stream (the mem/wb stage output) and results from long-latency multi-cycle units (divider, CSR-side units) that return out of band. MCU results are buffered in a small FIFO and drained into free write slots. A starvation counter forces a one-cycle pipeline stall when the buffer is starved. A per-register busy scoreboard is kept for decode.

## Interface
- `DEPTH`, 2, MCU result FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, 4, consecutive non-draining cycles before a forced drain; 1..15.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `pipe_we_i` in 1: writeback write enable.
- `pipe_waddr_i` in 5: writeback destination.
- `pipe_wdata_i` in 32: writeback data.
- `pipe_retire_i` in 1: an instruction is retiring this cycle.
- `flush_int_i` in 1: interrupt flush; kills the current pipeline write.
- `pipe_stall_o` out 1: pipeline must hold mem/wb outputs this cycle.
- `mcu_issue_i` in 1: an MCU op was issued this cycle.
- `mcu_issue_rd_i` in 5: destination of the issued op.
- `mcu_valid_i` in 1: MCU result valid.
- `mcu_rd_i` in 5: MCU result destination.
- `mcu_data_i` in 32: MCU result data.
- `mcu_ready_o` out 1: FIFO can accept.
- `reg_we_o` out 1: regfile write enable (registered).
- `reg_waddr_o` out 5: regfile write address (registered).
- `reg_wdata_o` out 32: regfile write data (registered).
- `instret_incr_o` out 1: retired-instruction pulse (registered).
- `busy_o` out 32: per-register pending-MCU-write bitmap; bit 0 always 0.
- `fwd_valid_o` out 1: forwarding valid (macro-dependent).
- `fwd_addr_o` out 5: forwarding address (macro-dependent).
- `fwd_data_o` out 32: forwarding data (macro-dependent).

## Operation
- Pipeline request: `preq = pipe_we_i & (pipe_waddr_i != 0) & ~flush_int_i`. Writes to x0 and flushed writes are dropped.
- MCU accept: `mcu_valid_i & mcu_ready_o`, where `mcu_ready_o = ~full`. A result with rd=0 is accepted but not pushed.
- Starvation counter `cnt`:
  - Increments each cycle the FIFO is non-empty and does not pop.
  - Clears on pop or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- Forced drain: `force = (cnt == STARVE_LIMIT) & nonempty`.
- Grant, decided per cycle:
  - If `force`, FIFO head wins. `pipe_stall_o = preq` (combinational); the pipeline re-presents the same write next cycle.
  - Else if `preq`, the pipeline wins.
  - Else if nonempty, FIFO head wins.
  - Else no write.
- Pop: occurs whenever the FIFO head wins.
- Winner: registered onto `reg_*_o` at the next edge. No winner means `reg_we_o=0`, address/data 0.
- Retire pulse: `instret_incr_o <= pipe_retire_i & ~pipe_stall_o & ~flush_int_i`.
- Busy scoreboard:
  - Set: `mcu_issue_i` with rd≠0 sets `busy[rd]`.
  - Clear: pop of head rd clears `busy[rd]`.
  - Same rd set and cleared in one cycle: set wins.
- Push and pop in the same cycle: allowed when not full. Occupancy is unchanged.
- Flush: `flush_int_i` does not affect FIFO contents, busy bits or `cnt`. Buffered results belong to committed ops.

## Timing
- Pipeline write to `reg_we_o`: 1 cycle.
- MCU accept to earliest `reg_we_o`: 2 cycles (push at edge N, pop at N+1, visible after N+1).
- Worst-case MCU head wait under continuous pipeline writes: `STARVE_LIMIT+1` cycles after reaching head.
- Reset (async assert, sync deassert upstream):
  - `reg_we_o=0`, `reg_waddr_o=0`, `reg_wdata_o=0`, `instret_incr_o=0`.
  - FIFO empty, `cnt=0`, `busy_o=0`, `mcu_ready_o=1`.
  - `pipe_stall_o=0`, `fwd_*=0`.
- Reset mid-operation discards buffered results and busy bits.
- Full FIFO: `mcu_ready_o=0`; the MCU holds its result. There is no pass-through when full.
- FIFO pointers: log2(DEPTH)+1 bits; full/empty is decided by the MSB compare; pointers wrap naturally.

## Configuration
- `WB_ARB_BYPASS_EN` defined:
  - `fwd_valid_o/addr/data` combinationally mirror the current-cycle winner (pre-register), for decode bypass.
  - `busy_o` bit for the popping rd reads 0 in the pop cycle.
- Not defined:
  - `fwd_*` tied to 0.
  - `busy_o` is the registered bitmap only.

## Structure
- Shared package/defines: `RADDR_WIDTH`, `RDATA_WIDTH`, `ZERO_REG`, `ZERO`, `WRITE_DISABLE` (existing `defines.v`); add `WB_ARB_DEPTH`, `WB_ARB_STARVE_LIMIT`.
- One sub-module `wb_result_fifo`: parameterised DEPTH×37-bit synchronous FIFO with push/pop/full/empty. Arbitration, counter and scoreboard live in `wb_arbiter`.

## Test plan
- Pipeline write x5=0xDEADBEEF, FIFO empty -> next cycle `reg_we_o=1`, `reg_waddr_o=5`, `reg_wdata_o=0xDEADBEEF`; pipeline write to x0 -> `reg_we_o=0`.
- MCU result x7=0x12 while pipeline idle -> `reg_we_o` two cycles after accept with addr 7 / data 0x12; `busy_o[7]` set at issue, cleared after pop.
- Pipeline writes every cycle, one MCU result queued, `STARVE_LIMIT`=4 -> `pipe_stall_o=1` exactly once, 4 cycles after push+1; the FIFO write appears; the held pipeline write appears next cycle unchanged.
- Push `DEPTH` results with the pipeline busy -> `mcu_ready_o=0`; the third MCU valid is held until a pop; no data loss, order preserved.
- `flush_int_i=1` with pipeline write x3 and a queued MCU x9 -> x3 not written, `instret_incr_o=0`, x9 still drains.
- Assert `rst_ni=0` with 2 entries queued -> all outputs 0 immediately, `busy_o=0`, `mcu_ready_o=1`; no stale writes after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths, constants and types for the writeback arbiter slice.
// Mirrors the legacy defines.v constants and adds the arbiter defaults.
package wb_arbiter_pkg;

  localparam int RADDR_WIDTH = 5;
  localparam int RDATA_WIDTH = 32;
  localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;
  localparam logic [RDATA_WIDTH-1:0] ZERO = '0;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam int WB_ARB_DEPTH = 2;
  localparam int WB_ARB_STARVE_LIMIT = 4;

  localparam int CNT_WIDTH = 4;
  localparam int ENTRY_WIDTH = RADDR_WIDTH + RDATA_WIDTH;

  typedef struct packed {
    logic [RADDR_WIDTH-1:0] rd;
    logic [RDATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_FIFO
  } wb_grant_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding buffered multi-cycle-unit results.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs buffered MCU results,
// with starvation-forced drains and a busy scoreboard. Option: WB_ARB_BYPASS_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = WB_ARB_DEPTH,
  parameter int STARVE_LIMIT = WB_ARB_STARVE_LIMIT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pipe_we_i,
  input  logic [RADDR_WIDTH-1:0] pipe_waddr_i,
  input  logic [RDATA_WIDTH-1:0] pipe_wdata_i,
  input  logic                   pipe_retire_i,
  input  logic                   flush_int_i,
  output logic                   pipe_stall_o,
  input  logic                   mcu_issue_i,
  input  logic [RADDR_WIDTH-1:0] mcu_issue_rd_i,
  input  logic                   mcu_valid_i,
  input  logic [RADDR_WIDTH-1:0] mcu_rd_i,
  input  logic [RDATA_WIDTH-1:0] mcu_data_i,
  output logic                   mcu_ready_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                   instret_incr_o,
  output logic [31:0]            busy_o,
  output logic                   fwd_valid_o,
  output logic [RADDR_WIDTH-1:0] fwd_addr_o,
  output logic [RDATA_WIDTH-1:0] fwd_data_o
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  logic                   preq;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [ENTRY_WIDTH-1:0] fifo_rdata;
  wb_entry_t              head;
  logic                   force_drain;
  wb_grant_e              grant;
  logic                   win_we;
  logic [RADDR_WIDTH-1:0] win_addr;
  logic [RDATA_WIDTH-1:0] win_data;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [31:0]            busy_q;
  logic [31:0]            busy_set;
  logic [31:0]            busy_clr;

  assign preq        = pipe_we_i && (pipe_waddr_i != ZERO_REG) && !flush_int_i;
  assign mcu_ready_o = !fifo_full;
  // Results for x0 are consumed but never occupy a slot.
  assign fifo_push   = mcu_valid_i && !fifo_full && (mcu_rd_i != ZERO_REG);
  assign head        = wb_entry_t'(fifo_rdata);
  assign force_drain = (cnt_q == LIMIT) && !fifo_empty;
  assign fifo_pop    = (grant == GNT_FIFO);
  assign pipe_stall_o = force_drain && preq;

  wb_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i ({mcu_rd_i, mcu_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    grant    = GNT_NONE;
    win_we   = WRITE_DISABLE;
    win_addr = ZERO_REG;
    win_data = ZERO;
    if (force_drain)      grant = GNT_FIFO;
    else if (preq)        grant = GNT_PIPE;
    else if (!fifo_empty) grant = GNT_FIFO;
    case (grant)
      GNT_PIPE: begin
        win_we   = 1'b1;
        win_addr = pipe_waddr_i;
        win_data = pipe_wdata_i;
      end
      GNT_FIFO: begin
        win_we   = 1'b1;
        win_addr = head.rd;
        win_data = head.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (fifo_empty || fifo_pop) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_we_o       <= WRITE_DISABLE;
      reg_waddr_o    <= ZERO_REG;
      reg_wdata_o    <= ZERO;
      instret_incr_o <= 1'b0;
    end else begin
      reg_we_o       <= win_we;
      reg_waddr_o    <= win_addr;
      reg_wdata_o    <= win_data;
      instret_incr_o <= pipe_retire_i && !pipe_stall_o && !flush_int_i;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  assign busy_clr = fifo_pop ? (32'd1 << head.rd) : 32'd0;
  assign busy_set = (mcu_issue_i && (mcu_issue_rd_i != ZERO_REG)) ? (32'd1 << mcu_issue_rd_i) : 32'd0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= ((busy_q & ~busy_clr) | busy_set) & ~32'd1;
    end
  end

`ifdef WB_ARB_BYPASS_EN
  assign busy_o      = busy_q & ~busy_clr;
  assign fwd_valid_o = win_we;
  assign fwd_addr_o  = win_addr;
  assign fwd_data_o  = win_data;
`else
  assign busy_o      = busy_q;
  assign fwd_valid_o = 1'b0;
  assign fwd_addr_o  = ZERO_REG;
  assign fwd_data_o  = ZERO;
`endif

endmodule
